signed_int_to_float: RTL and testbench

SIGNED_INT_TO_FLOAT -- requirements
Module: signed_int_to_float

---
 rtl/fp_pkg.sv | 13 +
 rtl/fp_round_rne.sv | 17 +
 rtl/signed_int_to_float.sv | 69 ++++++
 tb/tb_signed_int_to_float.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared single-precision field widths, FSM states and float layout
package fp_pkg;
  localparam int SIGN_W = 1;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int EXP_BIAS = 127;
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exp;
    logic [MAN_W-1:0]  man;
  } fp32_t;
endpackage

// File: rtl/fp_round_rne.sv
// fp_round_rne: round-to-nearest-even on a 23-bit mantissa with exponent carry
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MAN_W-1:0] man,
  input  logic             guard,
  input  logic             sticky,
  input  logic [EXP_W-1:0] exp,
  output logic [MAN_W-1:0] man_r,
  output logic [EXP_W-1:0] exp_r
);
  logic inc;
  logic carry;
  assign inc = guard && (sticky || man[0]);
  assign {carry, man_r} = {1'b0, man} + (MAN_W+1)'(inc);
  assign exp_r = exp + EXP_W'(carry);
endmodule

// File: rtl/signed_int_to_float.sv
// signed_int_to_float: iterative int32 to IEEE-754 single conversion with valid/ready handshakes
module signed_int_to_float
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] signed_int_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] FP_val
);
  state_t state, state_next;
  logic [31:0] mag, mag_in;
  logic [SIGN_W-1:0] sign;
  logic [4:0] lz_cnt;
  logic [EXP_W-1:0] exp_pre, exp_r;
  logic [MAN_W-1:0] man_r;
  fp32_t fp_val;
  logic accept, consume;
  assign mag_in = signed_int_val[31] ? -signed_int_val : signed_int_val;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign consume = out_valid && out_ready;
  assign FP_val = fp_val;
  assign exp_pre = EXP_W'(EXP_BIAS + 31) - {3'b000, lz_cnt};
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? (mag_in == '0 ? DONE : NORM) : IDLE;
      NORM:    state_next = mag[31] ? ROUND : NORM;
      ROUND:   state_next = DONE;
      DONE:    state_next = consume ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end
  fp_round_rne u_round (
    .man    (mag[30:8]),
    .guard  (mag[7]),
    .sticky (|mag[6:0]),
    .exp    (exp_pre),
    .man_r  (man_r),
    .exp_r  (exp_r)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mag    <= '0;
      sign   <= '0;
      lz_cnt <= '0;
      fp_val <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        mag    <= mag_in;
        sign   <= signed_int_val[31];
        lz_cnt <= '0;
        fp_val <= '0;
      end
      if (state == NORM && !mag[31]) begin
        mag    <= mag << 1;
        lz_cnt <= lz_cnt + 5'd1;
      end
      if (state == ROUND) fp_val <= '{sign: sign, exp: exp_r, man: man_r};
    end
  end
endmodule

// File: tb/tb_signed_int_to_float.sv
// tb_signed_int_to_float: directed and random checks against an integer rounding model
module tb_signed_int_to_float;
  logic clk = 0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] signed_int_val, FP_val;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  bit rand_mode = 0;
  always #5 clk = ~clk;
  signed_int_to_float dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .signed_int_val(signed_int_val), .out_valid(out_valid),
    .out_ready(out_ready), .FP_val(FP_val)
  );
  function automatic logic [31:0] ref_fp(input logic [31:0] v);
    longint m, q, r, half;
    int e, sh;
    logic s;
    s = v[31];
    m = longint'($signed(v));
    if (m < 0) m = -m;
    if (m == 0) return 32'h0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) q = m << (23 - e);
    else begin
      sh = e - 23;
      q = m >> sh;
      r = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (r > half || (r == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {s, 8'(e + 127), q[22:0]};
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask
  always @(posedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) exp_q.push_back(ref_fp(signed_int_val));
    end
  end
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output got %h expected no result", FP_val);
      end else chk("stream", FP_val, exp_q[0]);
    end
  end
  task automatic send(input logic [31:0] v);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready 0 expected 1");
    end
    in_valid = 1;
    signed_int_val = v;
    @(posedge clk);
    #1 in_valid = 0;
    signed_int_val = $urandom;
  endtask
  task automatic wait_out(output int edges);
    edges = 1;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1 edges++;
    end
  endtask
  task automatic op(input string name, input logic [31:0] v, input logic [31:0] fp, input int lat);
    int e;
    send(v);
    wait_out(e);
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk(name, FP_val, fp);
    if (lat > 0) chk({name, "_latency"}, 32'(e), 32'(lat));
    @(posedge clk);
    #1;
  endtask
  initial begin
    int e, n;
    logic [31:0] v;
    rst = 1; in_valid = 0; out_ready = 1; signed_int_val = 0;
    @(posedge clk);
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_fp", FP_val, 32'h0);
    rst = 0;
    chk("model_one", ref_fp(32'd1), 32'h3F800000);
    chk("model_tie_even", ref_fp(32'd16777217), 32'h4B800000);
    chk("model_max", ref_fp(32'h7FFFFFFF), 32'h4F000000);
    chk("model_min", ref_fp(32'h80000000), 32'hCF000000);
    op("one", 32'd1, 32'h3F800000, 34);
    op("minus_one", 32'hFFFFFFFF, 32'hBF800000, 34);
    op("zero", 32'd0, 32'h00000000, 1);
    op("max", 32'h7FFFFFFF, 32'h4F000000, 4);
    op("min", 32'h80000000, 32'hCF000000, 3);
    op("tie_down", 32'd16777217, 32'h4B800000, 10);
    op("tie_up", 32'd16777219, 32'h4B800002, 10);
    op("tie_even", 32'd16777221, 32'h4B800002, 10);
    out_ready = 0;
    send(32'd100);
    wait_out(e);
    chk("bp_first", FP_val, 32'h42C80000);
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold", FP_val, 32'h42C80000);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      in_valid = 1'($urandom_range(0, 1));
      signed_int_val = $urandom;
    end
    @(negedge clk);
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    send(32'd5);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_fp", FP_val, 32'h0);
    op("after_rst", 32'd7, 32'h40E00000, 32);
    rand_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
      end
      v = $urandom;
      if ($urandom_range(0, 1) == 1) v = v >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) v = -v;
      send(v);
    end
    rand_mode = 0;
    @(negedge clk);
    out_ready = 1;
    n = 0;
    while ((out_valid || exp_q.size() > 0) && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end
endmodule
